// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: pulls words from a FIFO with 1-cycle read latency into a skid buffer.
// Define RD_STATS_EN to add the words_out and stall_cycles counters.
module fifo_rd_stream #(
    parameter int FIFO_WIDTH = 16,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    output logic                         fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0]        fifo_data_out,
    input  logic                         fifo_empty,
    input  logic                         fifo_underflow,
    output logic                         m_valid,
    output logic [FIFO_WIDTH-1:0]        m_data,
    input  logic                         m_ready,
    output logic [$clog2(BUF_DEPTH):0]   buf_level,
`ifdef RD_STATS_EN
    output logic [31:0]                  words_out,
    output logic [31:0]                  stall_cycles,
`endif
    output logic                         proto_err
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int LW = AW + 1;

    logic [FIFO_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [FIFO_WIDTH-1:0] mem_d [BUF_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  inflight_q, inflight_d;
    logic                  proto_err_q, proto_err_d;
    logic [LW:0]           occ;
    logic                  push, pop;

    always_comb begin
        occ = {1'b0, level_q} + {{LW{1'b0}}, inflight_q};
        // Gated by rst_n so the strobe drops the instant reset asserts
        fifo_rd_en = rst_n & en & ~fifo_empty
                   & (occ < (LW+1)'(BUF_DEPTH));
        m_valid    = (level_q != '0);
        m_data     = mem_q[rd_ptr_q];
        buf_level  = level_q;
        proto_err  = proto_err_q;
        push       = inflight_q;
        pop        = m_valid & m_ready;
        inflight_d = fifo_rd_en;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = fifo_data_out;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        proto_err_d = proto_err_q | (fifo_rd_en & fifo_underflow);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            inflight_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            inflight_q  <= inflight_d;
            proto_err_q <= proto_err_d;
        end
    end

`ifdef RD_STATS_EN
    logic [31:0] words_q, words_d;
    logic [31:0] stall_q, stall_d;

    always_comb begin
        words_d      = words_q;
        stall_d      = stall_q;
        if (pop && words_q != 32'hFFFF_FFFF) begin
            words_d = words_q + 32'd1;
        end
        if (m_valid && !m_ready && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
        words_out    = words_q;
        stall_cycles = stall_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_q <= '0;
            stall_q <= '0;
        end else begin
            words_q <= words_d;
            stall_q <= stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural 1-cycle-latency FIFO model.
// Build with RD_STATS_EN defined to also exercise the statistics counters.
module tb_fifo_rd_stream;

    localparam int W = 16;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         fifo_rd_en;
    logic [W-1:0] fifo_data_out = '0;
    logic         fifo_empty;
    logic         fifo_underflow = 1'b0;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_ready = 1'b0;
    logic [$clog2(D):0] buf_level;
    logic         proto_err;
`ifdef RD_STATS_EN
    logic [31:0]  words_out;
    logic [31:0]  stall_cycles;
`endif

    int n_chk = 0;
    int n_fail = 0;

    logic [W-1:0] fbuf [512];
    int  wp = 0;
    int  rp = 0;
    bit  flush = 1'b0;
    logic [W-1:0] exp_q [$];

    fifo_rd_stream #(.FIFO_WIDTH(W), .BUF_DEPTH(D)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_data_out  (fifo_data_out),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready),
        .buf_level      (buf_level),
`ifdef RD_STATS_EN
        .words_out      (words_out),
        .stall_cycles   (stall_cycles),
`endif
        .proto_err      (proto_err)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (rp == wp);

    always @(posedge clk) begin
        if (flush) begin
            rp <= wp;
        end else if (fifo_rd_en && rp != wp) begin
            fifo_data_out <= fbuf[rp % 512];
            rp <= rp + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            n_chk++;
            assert (!(fifo_rd_en && fifo_empty)) else begin
                n_fail++;
                $error("FAIL rd_when_empty: observed rd_en=1 empty=1 expected no read");
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_w(input logic [W-1:0] d);
        fbuf[wp % 512] = d;
        wp++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input string tag, input logic [W-1:0] d);
        int t = 0;
        while (!m_valid && t < 20) begin
            tick();
            t++;
        end
        chk({tag, "_valid"}, 32'(m_valid), 32'd1);
        chk({tag, "_data"}, 32'(m_data), 32'(d));
        tick();
    endtask

    initial begin
        int r0;
        int seen;
        int pushed;
        int got;
        int cyc;
        logic [W-1:0] d;

        // reset state
        #1;
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_level", 32'(buf_level), 0);
        chk("rst_perr", 32'(proto_err), 0);
        tick();
        rst_n = 1'b1;

        // reset mid-burst
        for (int i = 0; i < 6; i++) push_w(16'h00A1 + 16'(i));
        en = 1'b1;
        m_ready = 1'b1;
        tick(); tick(); tick();
        chk("t1_mid_valid", 32'(m_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_rd_en", 32'(fifo_rd_en), 0);
        chk("t1_valid", 32'(m_valid), 0);
        chk("t1_level", 32'(buf_level), 0);
        chk("t1_perr", 32'(proto_err), 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (m_valid) seen++;
        end
        chk("t1_stale", 32'(seen), 0);

        // streaming latency and order
        en = 1'b0;
        for (int i = 1; i <= 8; i++) push_w(16'(i));
        tick();
        en = 1'b1;
        #1;
        chk("t2_rd_en_N", 32'(fifo_rd_en), 1);
        chk("t2_valid_N", 32'(m_valid), 0);
        tick();
        chk("t2_valid_N1", 32'(m_valid), 0);
        tick();
        for (int k = 1; k <= 8; k++) begin
            chk("t2_valid", 32'(m_valid), 1);
            chk("t2_data", 32'(m_data), 32'(k));
            tick();
        end
        chk("t2_drained", 32'(m_valid), 0);

        // back-pressure fills buffer to exactly BUF_DEPTH
        en = 1'b0;
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push_w(16'(i));
        tick();
        r0 = rp;
        en = 1'b1;
        repeat (8) tick();
        chk("t3_reads", 32'(rp - r0), 4);
        chk("t3_level", 32'(buf_level), 4);
        chk("t3_rd_en_full", 32'(fifo_rd_en), 0);
        chk("t3_hold_data", 32'(m_data), 1);
        repeat (3) tick();
        chk("t3_stable", 32'(m_data), 1);
        m_ready = 1'b1;
        for (int k = 1; k <= 8; k++) expect_word("t3", 16'(k));
        chk("t3_drained", 32'(m_valid), 0);

        // random traffic against scoreboard
        pushed = 0;
        got = 0;
        cyc = 0;
        while (got < 200 && cyc < 5000) begin
            if (pushed < 200 && $urandom_range(0, 1) == 1) begin
                d = 16'($urandom);
                push_w(d);
                exp_q.push_back(d);
                pushed++;
            end
            m_ready = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 3) != 0);
            #1;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("t4_extra", 32'(m_valid), 0);
                end else begin
                    chk("t4_data", 32'(m_data), 32'(exp_q.pop_front()));
                end
                got++;
            end
            tick();
            cyc++;
        end
        chk("t4_count", 32'(got), 200);
        chk("t4_left", 32'(exp_q.size()), 0);
        m_ready = 1'b1;
        en = 1'b1;
        seen = 0;
        repeat (8) begin
            tick();
            if (m_valid) seen++;
        end
        chk("t4_dup", 32'(seen), 0);

        // protocol error flag
        en = 1'b0;
        push_w(16'h5A5A);
        fifo_underflow = 1'b1;
        #1;
        chk("t5_rd_en_off", 32'(fifo_rd_en), 0);
        tick();
        chk("t5_no_own_read", 32'(proto_err), 0);
        en = 1'b1;
        #1;
        chk("t5_rd_en_on", 32'(fifo_rd_en), 1);
        tick();
        fifo_underflow = 1'b0;
        chk("t5_set", 32'(proto_err), 1);
        repeat (4) tick();
        chk("t5_sticky", 32'(proto_err), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_cleared", 32'(proto_err), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_after_rst", 32'(proto_err), 0);

`ifdef RD_STATS_EN
        rst_n = 1'b0;
        en = 1'b0;
        m_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_rst_words", words_out, 0);
        chk("t6_rst_stall", stall_cycles, 0);
        for (int i = 0; i < 10; i++) push_w(16'h0010 + 16'(i));
        en = 1'b1;
        cyc = 0;
        while (!m_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("t6_valid", 32'(m_valid), 1);
        repeat (3) tick();
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) expect_word("t6", 16'h0010 + 16'(i));
        chk("t6_words", words_out, 10);
        chk("t6_stall", stall_cycles, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
